// File: rtl/local_store.sv
// SPU local store: DEPTH x 128-bit quadword array serving odd-pipe loads and stores.
// Loads return through a fixed RD_LATENCY pipeline tagged with the destination register.
// After reset the whole array is swept to zero before any request is accepted.
`timescale 1ns/1ps
module local_store #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [0:ADDR_W-1] req_address,
    input  logic [0:127]      req_data,
    input  logic [0:6]        req_rt_address,
    output logic              rsp_valid,
    output logic [0:127]      rsp_data,
    output logic [0:6]        rsp_rt_address,
    output logic              init_done
);

    // Quadword index width: the byte address minus its 4 offset bits.
    localparam int IDX_W = ADDR_W - 4;

    typedef enum logic [0:0] {
        INIT,
        READY
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_last;

    logic [IDX_W-1:0] req_idx;
    logic             unused_offset_bits;
    logic             accept;
    logic             accept_load;
    logic             accept_store;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [0:127]     mem_wdata;
    logic [0:127]     mem [DEPTH];

    logic [0:RD_LATENCY-1] pipe_valid;
    logic [0:127]          pipe_data [RD_LATENCY];
    logic [0:6]            pipe_tag  [RD_LATENCY];

    // Quadword index is the upper address bits; the byte offset within a quadword is ignored,
    // and because every index value maps to an entry the address wraps naturally.
    assign req_idx            = req_address[0:ADDR_W-5];
    assign unused_offset_bits = ^req_address[ADDR_W-4:ADDR_W-1];

    assign clr_last = (clr_idx == IDX_W'(DEPTH - 1));

    // A request is taken only when the block is ready; reset overrides any handshake.
    assign accept       = req_valid && req_ready && !reset;
    assign accept_load  = accept && !req_write;
    assign accept_store = accept && req_write;

    // Single write port shared by the clear sweep and accepted stores (never both at once).
    assign mem_we    = !reset && ((state_q == INIT) || accept_store);
    assign mem_waddr = (state_q == INIT) ? clr_idx : req_idx;
    assign mem_wdata = (state_q == INIT) ? '0 : req_data;

    // State register and clear-sweep counter; the sweep restarts from entry 0 on every reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // Next-state and handshake outputs: sweep until the last entry is cleared, then stay ready.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state_q)
            INIT: begin
                if (clr_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Array write port; left without reset so it maps onto a RAM macro.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Load pipeline: read at the accepting edge, then shift valid/data/tag; data stages only
    // move when their valid does, so the response outputs hold between loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
                pipe_tag[i]   <= '0;
            end
        end else begin
            pipe_valid[0] <= accept_load;
            if (accept_load) begin
                pipe_data[0] <= mem[req_idx];
                pipe_tag[0]  <= req_rt_address;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_tag[i]  <= pipe_tag[i-1];
                end
            end
        end
    end

    assign rsp_valid      = pipe_valid[RD_LATENCY-1];
    assign rsp_data       = pipe_data[RD_LATENCY-1];
    assign rsp_rt_address = pipe_tag[RD_LATENCY-1];

endmodule

// File: tb/tb_local_store.sv
// Self-checking bench for local_store: table-driven vectors, hand-written corner sequences,
// and randomized traffic checked against a behavioural model of the local store.
`timescale 1ns/1ps
module tb_local_store;

    localparam int DEPTH      = 2048;
    localparam int ADDR_W     = 15;
    localparam int RD_LATENCY = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [0:ADDR_W-1] req_address = '0;
    logic [0:127]      req_data = '0;
    logic [0:6]        req_rt_address = '0;
    logic              rsp_valid;
    logic [0:127]      rsp_data;
    logic [0:6]        rsp_rt_address;
    logic              init_done;

    local_store #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_address(req_address),
        .req_data(req_data),
        .req_rt_address(req_rt_address),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_rt_address(rsp_rt_address),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    // Model: memory contents, readiness, and a queue of expected responses with due edge number.
    typedef struct {
        logic [127:0] data;
        logic [6:0]   tag;
        int           due;
    } rsp_t;

    typedef struct {
        bit           write;
        logic [14:0]  addr;
        logic [127:0] data;
        logic [6:0]   tag;
        bit           exp_rsp;
        logic [127:0] exp_data;
    } vec_t;

    rsp_t         exp_q[$];
    logic [127:0] ref_mem [DEPTH];
    logic [127:0] got_q[$];
    int           edge_cnt = 0;
    int           init_cnt = 0;
    bit           model_ready = 0;
    bit           check_en = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           rsp_seen = 0;
    logic [127:0] last_data = '0;
    logic [6:0]   last_tag = '0;
    int           rsp_count = 0;

    localparam logic [127:0] DA = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] DB = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] DC = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock edge, then update the model and compare every visible output.
    task automatic step();
        bit rst_edge;
        bit exp_valid;
        rsp_t e;
        rst_edge = reset;
        @(posedge clock);
        #1;
        edge_cnt++;
        if (rst_edge) begin
            model_ready = 0;
            init_cnt    = 0;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            check_en = 1;
        end else if (!model_ready) begin
            init_cnt++;
            if (init_cnt == DEPTH) model_ready = 1;
        end
        if (check_en) begin
            check_output("req_ready", {127'd0, req_ready}, {127'd0, model_ready});
            check_output("init_done", {127'd0, init_done}, {127'd0, model_ready});
            exp_valid = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
            check_output("rsp_valid", {127'd0, rsp_valid}, {127'd0, exp_valid});
            if (exp_valid) begin
                e = exp_q.pop_front();
                check_output("rsp_data", rsp_data, e.data);
                check_output("rsp_rt_address", {121'd0, rsp_rt_address}, {121'd0, e.tag});
            end
            if (rsp_valid === 1'b1) begin
                rsp_seen  = 1;
                last_data = rsp_data;
                last_tag  = rsp_rt_address;
                rsp_count++;
                got_q.push_back(rsp_data);
            end
        end
    endtask

    // Drive one request for one cycle and record its effect in the model if it is accepted.
    task automatic apply_stimulus(input bit v, input bit w, input logic [14:0] addr,
                                  input logic [127:0] d, input logic [6:0] tag);
        int   idx;
        rsp_t e;
        req_valid      = v;
        req_write      = w;
        req_address    = addr;
        req_data       = d;
        req_rt_address = tag;
        if (v && model_ready && !reset) begin
            idx = (int'(addr) / 16) % DEPTH;
            if (w) begin
                ref_mem[idx] = d;
            end else begin
                e.data = ref_mem[idx];
                e.tag  = tag;
                e.due  = edge_cnt + RD_LATENCY;
                exp_q.push_back(e);
            end
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, '0, '0, '0);
    endtask

    // Release reset and count edges until the block reports ready.
    task automatic wait_init(input string name);
        int n;
        n     = 0;
        reset = 1'b0;
        while (req_ready !== 1'b1 && n < DEPTH + 20) begin
            step();
            n++;
        end
        check_output(name, 128'(n), 128'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{1, 15'h0120, DA, 7'd0,   0, '0};
        vecs[1] = '{0, 15'h012C, '0, 7'd5,   1, DA};
        vecs[2] = '{1, 15'h7FF0, DB, 7'd0,   0, '0};
        vecs[3] = '{0, 15'h7FF0, '0, 7'd9,   1, DB};
        vecs[4] = '{0, 15'h0000, '0, 7'd10,  1, '0};
        vecs[5] = '{1, 15'h0007, DC, 7'd0,   0, '0};
        vecs[6] = '{0, 15'h000F, '0, 7'd11,  1, DC};
        vecs[7] = '{0, 15'h7FFF, '0, 7'd127, 1, DB};
        vecs[8] = '{0, 15'h0010, '0, 7'd0,   1, '0};

        // Reset values.
        reset = 1'b1;
        step();
        check_output("reset rsp_data", rsp_data, '0);
        check_output("reset rsp_rt_address", {121'd0, rsp_rt_address}, '0);
        wait_init("init cycles");

        // Table-driven stores and loads.
        for (int i = 0; i < 9; i++) begin
            rsp_seen = 0;
            apply_stimulus(1, vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].tag);
            idle(RD_LATENCY - 1);
            check_output($sformatf("vec%0d rsp_seen", i), {127'd0, rsp_seen}, {127'd0, vecs[i].exp_rsp});
            if (vecs[i].exp_rsp) begin
                check_output($sformatf("vec%0d data", i), last_data, vecs[i].exp_data);
                check_output($sformatf("vec%0d tag", i), {121'd0, last_tag}, {121'd0, vecs[i].tag});
            end
        end

        // Eight back-to-back loads of distinct pre-stored entries.
        for (int i = 0; i < 8; i++)
            apply_stimulus(1, 1, 15'(16'h0400 + i * 16), {4{32'hA5A50000 + 32'(i)}}, '0);
        rsp_count = 0;
        for (int i = 0; i < 8; i++)
            apply_stimulus(1, 0, 15'(16'h0400 + i * 16), '0, 7'(i));
        idle(RD_LATENCY + 2);
        check_output("b2b count", 128'(rsp_count), 128'd8);
        check_output("b2b last", last_data, {4{32'hA5A50007}});

        // Load then immediate store to the same entry, then reload.
        got_q.delete();
        apply_stimulus(1, 0, 15'h0400, '0, 7'd20);
        apply_stimulus(1, 1, 15'h0400, DC, '0);
        apply_stimulus(1, 0, 15'h0400, '0, 7'd21);
        idle(RD_LATENCY + 2);
        check_output("hazard count", 128'(got_q.size()), 128'd2);
        if (got_q.size() == 2) begin
            check_output("hazard old", got_q[0], {4{32'hA5A50000}});
            check_output("hazard new", got_q[1], DC);
        end

        // Reset three cycles after four loads: in-flight loads are discarded, array cleared.
        apply_stimulus(1, 1, 15'h0900, DA, '0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1, 0, 15'(16'h0900 + i * 16), '0, 7'(30 + i));
        idle(2);
        reset = 1'b1;
        step();
        rsp_count = 0;
        wait_init("reinit cycles");
        check_output("no rsp after reset", 128'(rsp_count), '0);
        rsp_seen = 0;
        apply_stimulus(1, 0, 15'h0900, '0, 7'd3);
        idle(RD_LATENCY - 1);
        check_output("post reset seen", {127'd0, rsp_seen}, 128'd1);
        check_output("post reset data", last_data, '0);

        // Randomized traffic concentrated on a few entries so loads and stores interact.
        for (int i = 0; i < 400; i++) begin
            bit           v;
            bit           w;
            logic [14:0]  a;
            v = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 15'($urandom);
            else a = 15'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
            apply_stimulus(v, w, a, {$urandom, $urandom, $urandom, $urandom}, 7'($urandom));
        end
        idle(RD_LATENCY + 2);
        check_output("drain", 128'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
